// File: rtl/gameport_timer.sv
// ============================================================================
// gameport_timer
// ----------------------------------------------------------------------------
// Purpose:
//    PC game-port (201h) analog timer and button front end for NUM_STICKS
//    joysticks. A CPU write to the port fires every axis one-shot at once.
//    Each axis bit then reads 1 until a shared counter, advanced by a
//    prescaled tick, reaches that axis' threshold. Thresholds are taken from
//    the signed 8-bit stick position at the moment of the write, so the stick
//    can move freely while a measurement runs. Sticks 0 and 1 can be exchanged
//    so a player can use either physical controller as "player one".
//
// Parameters:
//    NUM_STICKS  number of sticks (>=1), each with an X and a Y axis
//    BTNS        buttons per stick
//    CNT_W       axis counter width (>=8); thresholds are scaled up to it
//    PRE_LOG     prescaler low bits; tick period is (cpu_speed+1)*2^PRE_LOG
//
// Ports:
//    clk_cpu     in   system clock
//    reset       in   synchronous, active-high
//    cpu_speed   in   CPU divider code (0 = fastest); stretches the tick
//    swap        in   1 = exchange stick 0 and stick 1 (analog and buttons)
//    joy_wr      in   one-cycle port write strobe, fires the one-shots
//    analog      in   per stick k: [16k+15:16k+8] X, [16k+7:16k] Y, signed
//    buttons     in   per stick k: [BTNS*k +: BTNS], 1 = pressed
//    axis_out    out  [2k] = X of stick k, [2k+1] = Y of stick k, 1 = timing
//    btn_out     out  registered inverted buttons after swap, 0 = pressed
//    busy        out  1 while a measurement is in progress
// ============================================================================
module gameport_timer #(
   parameter int NUM_STICKS = 2,
   parameter int BTNS       = 2,
   parameter int CNT_W      = 8,
   parameter int PRE_LOG    = 4
) (
   input  logic                         clk_cpu,
   input  logic                         reset,
   input  logic [4:0]                   cpu_speed,
   input  logic                         swap,
   input  logic                         joy_wr,
   input  logic [16*NUM_STICKS-1:0]     analog,
   input  logic [BTNS*NUM_STICKS-1:0]   buttons,
   output logic [2*NUM_STICKS-1:0]      axis_out,
   output logic [BTNS*NUM_STICKS-1:0]   btn_out,
   output logic                         busy
);

   localparam int NAXES = 2 * NUM_STICKS;
   localparam int PRE_W = 5 + PRE_LOG;

   localparam logic [CNT_W-1:0] CNT_IDLE = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

   // The measurement state is not stored separately: the counter parked at
   // all ones is the idle condition, any other value means a run is active.
   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   logic [CNT_W-1:0]                 r_cnt;
   logic [PRE_W-1:0]                 r_pre;
   logic                             r_tick;
   logic [NAXES-1:0]                 r_axis;
   logic [BTNS*NUM_STICKS-1:0]       r_btn;
   logic [NAXES-1:0][CNT_W-1:0]      r_thr;

   logic [16*NUM_STICKS-1:0]         w_swAnalog;
   logic [BTNS*NUM_STICKS-1:0]       w_swButtons;
   logic [NAXES-1:0][CNT_W-1:0]      w_thrLoad;
   logic [PRE_W-1:0]                 w_preWrap;
   state_t                           w_state;

   logic [CNT_W-1:0]                 w_cntNext;
   logic [PRE_W-1:0]                 w_preNext;
   logic                             w_tickNext;
   logic [NAXES-1:0]                 w_axisNext;
   logic [NAXES-1:0][CNT_W-1:0]      w_thrNext;

   // Stick exchange. Only sticks 0 and 1 ever move; with a single stick there
   // is nothing to exchange, so the swap input is simply not looked at.
   generate
      if (NUM_STICKS >= 2) begin : gSwap
         always_comb begin
            w_swAnalog  = analog;
            w_swButtons = buttons;
            if (swap) begin
               w_swAnalog[15:0]            = analog[31:16];
               w_swAnalog[31:16]           = analog[15:0];
               w_swButtons[BTNS-1:0]       = buttons[2*BTNS-1:BTNS];
               w_swButtons[2*BTNS-1:BTNS]  = buttons[BTNS-1:0];
            end
         end
      end else begin : gNoSwap
         logic w_unusedSwap;
         assign w_unusedSwap = swap;
         assign w_swAnalog   = analog;
         assign w_swButtons  = buttons;
      end
   endgenerate

   // Turn each signed stick position into an unsigned counter threshold by
   // flipping the sign bit (-128 -> 0, 0 -> 128, +127 -> 255) and placing the
   // result in the top 8 bits of the counter, which scales it to CNT_W.
   always_comb begin
      w_thrLoad = '0;
      for (int k = 0; k < NUM_STICKS; k++) begin
         w_thrLoad[2*k][CNT_W-1 -: 8]   = {~w_swAnalog[16*k+15], w_swAnalog[16*k+8 +: 7]};
         w_thrLoad[2*k+1][CNT_W-1 -: 8] = {~w_swAnalog[16*k+7],  w_swAnalog[16*k +: 7]};
      end
   end

   // The prescaler wraps when its upper bits equal the speed code and its low
   // PRE_LOG bits are all ones, giving (cpu_speed+1)*2^PRE_LOG clocks a tick.
   assign w_preWrap = {cpu_speed, {PRE_LOG{1'b1}}};

   // Decode the run/idle condition from the parked counter value.
   always_comb begin
      w_state = (r_cnt == CNT_IDLE) ? IDLE : RUN;
   end

   // Next-state logic. The prescaler free-runs in both states. A port write
   // always wins and restarts everything, even in the middle of a run, with
   // freshly snapshotted thresholds. During a run each axis drops once the
   // counter equals its threshold and stays low until the next write. When
   // idle every axis is held low, which also catches axes whose threshold was
   // all ones and so could never match while running.
   always_comb begin
      w_preNext  = r_pre + PRE_ONE;
      if (r_pre == w_preWrap) begin
         w_preNext = '0;
      end
      w_tickNext = (r_pre == '0);
      w_cntNext  = r_cnt;
      w_axisNext = r_axis;
      w_thrNext  = r_thr;

      if (joy_wr) begin
         w_cntNext  = '0;
         w_preNext  = PRE_ONE;
         w_tickNext = 1'b0;
         w_axisNext = '1;
         w_thrNext  = w_thrLoad;
      end else begin
         case (w_state)
            RUN: begin
               for (int i = 0; i < NAXES; i++) begin
                  if (r_cnt == r_thr[i]) begin
                     w_axisNext[i] = 1'b0;
                  end
               end
               if (r_tick) begin
                  w_cntNext = r_cnt + CNT_ONE;
               end
            end
            default: begin
               w_axisNext = '0;
            end
         endcase
      end
   end

   // State registers. Reset has priority over a simultaneous port write and
   // returns the block to idle with every axis low and all buttons released.
   // The button outputs are refreshed every cycle in port polarity.
   always_ff @(posedge clk_cpu) begin
      if (reset) begin
         r_cnt  <= CNT_IDLE;
         r_pre  <= '0;
         r_tick <= 1'b0;
         r_axis <= '0;
         r_btn  <= '1;
         r_thr  <= '0;
      end else begin
         r_cnt  <= w_cntNext;
         r_pre  <= w_preNext;
         r_tick <= w_tickNext;
         r_axis <= w_axisNext;
         r_btn  <= ~w_swButtons;
         r_thr  <= w_thrNext;
      end
   end

   assign axis_out = r_axis;
   assign btn_out  = r_btn;
   assign busy     = (w_state == RUN);

endmodule
